// File: rtl/aes_core_bus.sv
// AES-128/256 iterative core on a 4b address / 16b write / 8b registered-read bus; no backpressure, host polls STATUS.
// Key expansion takes Nr+1 clocks and a block Nr+1 clocks; defining AES_DECRYPT_EN adds the inverse cipher for encdec=0.
`timescale 1ns/1ps
module aes_core_bus (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  address,
   input  logic [15:0] data_in,
   output logic [7:0]  data_out
);

   localparam logic [3:0] A_CONFIG = 4'd1;
   localparam logic [3:0] A_KEY    = 4'd2;
   localparam logic [3:0] A_BLOCK  = 4'd3;
   localparam logic [3:0] A_STATUS = 4'd5;
   localparam logic [3:0] A_START  = 4'd6;
   localparam logic [3:0] A_RESULT = 4'd7;

   typedef enum logic [1:0] {B_IDLE, B_LOAD_KEY, B_LOAD_BLOCK, B_READ} bus_st_t;
   typedef enum logic [1:0] {C_IDLE, C_KEYEXP, C_ROUND} core_st_t;

   // GF(2^8) arithmetic; the S-box is computed as inverse followed by the affine map.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r, t;
      r = 8'h01;
      t = x;
      for (int i = 1; i < 8; i++) begin
         t = gf_mul(t, t);
         r = gf_mul(r, t);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 1; k < 10; k++) begin
         if (k < int'(n)) r = xtime(r);
      end
      return r;
   endfunction

   // AES-256 even steps and every AES-128 step use RotWord+Rcon; AES-256 odd steps use SubWord only.
   function automatic logic [127:0] expand_rk(input logic [127:0] p2, input logic [127:0] p1,
                                              input logic is256, input logic [3:0] i);
      logic [31:0]  t, w0, w1, w2, w3;
      logic [127:0] base;
      t = p1[31:0];
      if (!is256 || !i[0])
         t = sub_word({t[23:0], t[31:24]}) ^ {rcon(is256 ? {1'b0, i[3:1]} : i), 24'h000000};
      else
         t = sub_word(t);
      base = is256 ? p2 : p1;
      w0 = base[127:96] ^ t;
      w1 = base[95:64] ^ w0;
      w2 = base[63:32] ^ w1;
      w3 = base[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [15:0][7:0] a, o;
      a = s;
      for (int k = 0; k < 16; k++) o[k] = sbox(a[k]);
      return o;
   endfunction

   // Byte k (MSB first) sits at column k/4, row k%4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [15:0][7:0] a, o;
      a = s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[15 - (4*c + r)] = a[15 - (4*((c + r) % 4) + r)];
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
   endfunction

`ifdef AES_DECRYPT_EN
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [15:0][7:0] a, o;
      a = s;
      for (int k = 0; k < 16; k++) o[k] = inv_sbox(a[k]);
      return o;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [15:0][7:0] a, o;
      a = s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[15 - (4*c + r)] = a[15 - (4*((c + 4 - r) % 4) + r)];
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]), inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
   endfunction
`endif

   bus_st_t          bus_q, bus_d;
   core_st_t         core_q, core_d;
   logic [3:0]       lcnt_q, lcnt_d;
   logic [3:0]       ctr_q, ctr_d;
   logic [255:0]     key_q, key_d;
   logic [127:0]     blk_q, blk_d;
   logic [127:0]     st_q, st_d;
   logic [127:0]     res_q, res_d;
   logic [127:0]     rk_q [15];
   logic [127:0]     rk_d [15];
   logic             encdec_q, encdec_d;
   logic             keylen_q, keylen_d;
   logic             ready_q, ready_d;
   logic             valid_q, valid_d;
   logic             kv_q, kv_d;
   logic [7:0]       dout_q, dout_d;

   logic             init_p, next_p, kl_chg, rd_done;
   logic             dec, last_rnd;
   logic [3:0]       nr;
   logic [127:0]     rk_p1, rk_p2, rk_new, rk_cur, enc_t, rnd_out;
   logic [15:0][7:0] res_b;
`ifdef AES_DECRYPT_EN
   logic [127:0]     dec_t;
   assign dec = ~encdec_q;
`else
   assign dec = 1'b0;
`endif

   assign nr       = keylen_q ? 4'd14 : 4'd10;
   assign last_rnd = (ctr_q == nr);
   assign res_b    = res_q;
   assign data_out = dout_q;

   // Bus FSM: command decode, word loading, result streaming.
   always_comb begin
      bus_d    = bus_q;
      lcnt_d   = lcnt_q;
      key_d    = key_q;
      blk_d    = blk_q;
      encdec_d = encdec_q;
      keylen_d = keylen_q;
      dout_d   = 8'h00;
      init_p   = 1'b0;
      next_p   = 1'b0;
      kl_chg   = 1'b0;
      rd_done  = 1'b0;
      if (address == A_STATUS && bus_q != B_READ) dout_d = {6'b0, valid_q, ready_q};
      case (bus_q)
         B_IDLE: begin
            if (address == A_RESULT) begin
               dout_d = res_q[127:120];
               lcnt_d = 4'd1;
               bus_d  = B_READ;
            end else if (core_q == C_IDLE) begin
               case (address)
                  A_CONFIG: begin
                     encdec_d = data_in[0];
                     keylen_d = data_in[1];
                     kl_chg   = (data_in[1] != keylen_q);
                  end
                  A_KEY: begin
                     bus_d  = B_LOAD_KEY;
                     lcnt_d = 4'd0;
                  end
                  A_BLOCK: begin
                     bus_d  = B_LOAD_BLOCK;
                     lcnt_d = 4'd0;
                  end
                  A_START: begin
                     init_p = data_in[0];
                     next_p = data_in[1];
                     dout_d = {4'b0, keylen_q, encdec_q, data_in[1], data_in[0]};
                  end
                  default: ;
               endcase
            end
         end
         B_LOAD_KEY: begin
            key_d  = {key_q[239:0], data_in};
            lcnt_d = lcnt_q + 4'd1;
            if (lcnt_q == (keylen_q ? 4'd15 : 4'd7)) begin
               bus_d  = B_IDLE;
               lcnt_d = 4'd0;
            end
         end
         B_LOAD_BLOCK: begin
            blk_d  = {blk_q[111:0], data_in};
            lcnt_d = lcnt_q + 4'd1;
            if (lcnt_q == 4'd7) begin
               bus_d  = B_IDLE;
               lcnt_d = 4'd0;
            end
         end
         B_READ: begin
            dout_d = res_b[~lcnt_q];
            lcnt_d = lcnt_q + 4'd1;
            if (lcnt_q == 4'd15) begin
               bus_d   = B_IDLE;
               lcnt_d  = 4'd0;
               rd_done = 1'b1;
            end
         end
         default: bus_d = B_IDLE;
      endcase
   end

   // Round-key and round datapath.
   always_comb begin
      rk_p1 = rk_q[(ctr_q == 4'd0) ? 4'd0 : ctr_q - 4'd1];
      rk_p2 = rk_q[(ctr_q < 4'd2) ? 4'd0 : ctr_q - 4'd2];
      if (ctr_q == 4'd0)
         rk_new = keylen_q ? key_q[255:128] : key_q[127:0];
      else if (ctr_q == 4'd1 && keylen_q)
         rk_new = key_q[127:0];
      else
         rk_new = expand_rk(rk_p2, rk_p1, keylen_q, ctr_q);

      rk_cur  = rk_q[dec ? nr - ctr_q : ctr_q];
      enc_t   = shift_rows(sub_bytes(st_q));
      rnd_out = (last_rnd ? enc_t : mix_columns(enc_t)) ^ rk_cur;
`ifdef AES_DECRYPT_EN
      dec_t = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_cur;
      if (dec) rnd_out = last_rnd ? dec_t : inv_mix_columns(dec_t);
`endif
   end

   // Core FSM; bus-side ready updates come first so core events take priority.
   always_comb begin
      core_d  = core_q;
      ctr_d   = ctr_q;
      rk_d    = rk_q;
      st_d    = st_q;
      res_d   = res_q;
      ready_d = ready_q;
      valid_d = valid_q;
      kv_d    = kv_q;
      if (kl_chg) begin
         ready_d = 1'b0;
         kv_d    = 1'b0;
      end
      if (rd_done && core_q == C_IDLE && kv_q) ready_d = 1'b1;
      case (core_q)
         C_IDLE: begin
            if (init_p) begin
               core_d  = C_KEYEXP;
               ctr_d   = 4'd0;
               ready_d = 1'b0;
               valid_d = 1'b0;
               kv_d    = 1'b0;
            end else if (next_p && kv_q) begin
               core_d  = C_ROUND;
               st_d    = blk_q ^ rk_q[dec ? nr : 4'd0];
               ctr_d   = 4'd1;
               ready_d = 1'b0;
               valid_d = 1'b0;
            end
         end
         C_KEYEXP: begin
            rk_d[ctr_q] = rk_new;
            ctr_d       = ctr_q + 4'd1;
            if (ctr_q == nr) begin
               core_d  = C_IDLE;
               ready_d = 1'b1;
               kv_d    = 1'b1;
            end
         end
         C_ROUND: begin
            st_d  = rnd_out;
            ctr_d = ctr_q + 4'd1;
            if (last_rnd) begin
               core_d  = C_IDLE;
               res_d   = rnd_out;
               valid_d = 1'b1;
            end
         end
         default: core_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_q    <= B_IDLE;
         core_q   <= C_IDLE;
         lcnt_q   <= 4'd0;
         ctr_q    <= 4'd0;
         key_q    <= '0;
         blk_q    <= '0;
         st_q     <= '0;
         res_q    <= '0;
         for (int i = 0; i < 15; i++) rk_q[i] <= '0;
         encdec_q <= 1'b0;
         keylen_q <= 1'b0;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         kv_q     <= 1'b0;
         dout_q   <= 8'h00;
      end else begin
         bus_q    <= bus_d;
         core_q   <= core_d;
         lcnt_q   <= lcnt_d;
         ctr_q    <= ctr_d;
         key_q    <= key_d;
         blk_q    <= blk_d;
         st_q     <= st_d;
         res_q    <= res_d;
         rk_q     <= rk_d;
         encdec_q <= encdec_d;
         keylen_q <= keylen_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         kv_q     <= kv_d;
         dout_q   <= dout_d;
      end
   end

endmodule

// File: tb/tb_aes_core_bus.sv
// Directed bench for aes_core_bus: FIPS-197 vectors, status timing, command corner cases and async reset.
`timescale 1ns/1ps
module tb_aes_core_bus;

   localparam logic [3:0] A_IDLE   = 4'd0;
   localparam logic [3:0] A_CONFIG = 4'd1;
   localparam logic [3:0] A_KEY    = 4'd2;
   localparam logic [3:0] A_BLOCK  = 4'd3;
   localparam logic [3:0] A_STATUS = 4'd5;
   localparam logic [3:0] A_START  = 4'd6;
   localparam logic [3:0] A_RESULT = 4'd7;

   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  address;
   logic [15:0] data_in;
   logic [7:0]  data_out;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  sb [$];

   aes_core_bus dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic [3:0] a, input logic [15:0] d);
      address = a;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, want);
      end
   endtask

   task automatic config_wr(input logic encdec, input logic keylen);
      cyc(A_CONFIG, {14'b0, keylen, encdec});
   endtask

   task automatic load_key(input logic [255:0] k, input int nwords);
      cyc(A_KEY, 16'h0);
      for (int i = 0; i < nwords; i++) begin
         cyc(4'hf, k[255:240]);
         k = k << 16;
      end
   endtask

   task automatic load_block(input logic [127:0] b);
      cyc(A_BLOCK, 16'h0);
      for (int i = 0; i < 8; i++) begin
         cyc(4'hf, b[127:112]);
         b = b << 16;
      end
   endtask

   task automatic push_golden(input logic [127:0] v);
      for (int i = 0; i < 16; i++) begin
         sb.push_back(v[127:120]);
         v = v << 8;
      end
   endtask

   task automatic wait_status(input string tag, input logic [7:0] want, input int max_edges);
      int n;
      n = 0;
      do begin
         cyc(A_STATUS, 16'hffff);
         n++;
      end while (data_out !== want && n < max_edges);
      chk(tag, data_out, want);
   endtask

   task automatic read_result(input string tag);
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
         cyc((i == 0) ? A_RESULT : A_KEY, 16'h5a5a);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: byte %0d observed %02h expected none (scoreboard empty)", tag, i, data_out);
         end else begin
            e = sb.pop_front();
            chk(tag, data_out, e);
         end
      end
   endtask

   task automatic do_init(input string tag, input logic [255:0] k, input logic is256);
      load_key(k, is256 ? 16 : 8);
      cyc(A_START, 16'h0001);
      cyc(A_STATUS, 16'h0);
      chk({tag, "_status_busy"}, data_out, 8'h00);
      wait_status({tag, "_ready"}, 8'h01, is256 ? 17 : 13);
   endtask

   task automatic do_block(input string tag, input logic [127:0] b, input logic [127:0] golden, input logic is256);
      load_block(b);
      cyc(A_START, 16'h0002);
      push_golden(golden);
      wait_status({tag, "_valid"}, 8'h02, is256 ? 16 : 12);
      read_result({tag, "_result"});
      cyc(A_STATUS, 16'h0);
      chk({tag, "_status_done"}, data_out, 8'h03);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, observed no summary expected summary");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      address = A_IDLE;
      data_in = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dout", data_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         cyc(A_IDLE, 16'habcd);
         chk("idle_quiet", data_out, 8'h00);
      end
      cyc(A_STATUS, 16'hffff);
      chk("status_reset", data_out, 8'h00);

      // next with no round keys must be ignored
      load_block(PT);
      cyc(A_START, 16'h0002);
      chk("start_rb_next", data_out, 8'h02);
      for (int i = 0; i < 4; i++) begin
         cyc(A_STATUS, 16'h0);
         chk("next_no_init", data_out, 8'h00);
      end

      config_wr(1'b1, 1'b1);
      cyc(A_START, 16'h0000);
      chk("start_rb_cfg", data_out, 8'h0c);

      do_init("aes256", K256, 1'b1);
      do_block("aes256", PT, CT256, 1'b1);

      // keylen change drops ready and blocks next until re-init
      config_wr(1'b1, 1'b0);
      cyc(A_STATUS, 16'h0);
      chk("kl_change_status", data_out, 8'h02);
      cyc(A_START, 16'h0002);
      chk("start_rb_kl", data_out, 8'h06);
      cyc(A_STATUS, 16'h0);
      chk("next_after_kl", data_out, 8'h02);

      do_init("aes128", {K128, 128'h0}, 1'b0);
      do_block("aes128", PT, CT128, 1'b0);

      // init and next together: init wins, valid stays low
      cyc(A_START, 16'h0003);
      chk("start_rb_both", data_out, 8'h07);
      cyc(A_STATUS, 16'h0);
      chk("both_busy", data_out, 8'h00);
      wait_status("both_init_wins", 8'h01, 13);

      for (int it = 0; it < 100; it++) begin
         if (it % 2 == 0) begin
            config_wr(1'b1, 1'b1);
            do_init("b2b256", K256, 1'b1);
            do_block("b2b256", PT, CT256, 1'b1);
         end else begin
            config_wr(1'b1, 1'b0);
            do_init("b2b128", {K128, 128'h0}, 1'b0);
            do_block("b2b128", PT, CT128, 1'b0);
         end
      end

      config_wr(1'b0, 1'b1);
      do_init("dec256", K256, 1'b1);
`ifdef AES_DECRYPT_EN
      do_block("dec256", CT256, PT, 1'b1);
`else
      do_block("dec256", PT, CT256, 1'b1);
`endif

      // async reset in the middle of a block
      load_block(PT);
      cyc(A_START, 16'h0002);
      for (int i = 0; i < 3; i++) begin
         cyc(A_STATUS, 16'h0);
         chk("midop_busy", data_out, 8'h00);
      end
      rst_n = 1'b0;
      #2;
      chk("midop_reset_dout", data_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(A_STATUS, 16'h0);
      chk("midop_status", data_out, 8'h00);
      cyc(A_START, 16'h0000);
      chk("midop_cfg_cleared", data_out, 8'h00);
      push_golden(128'h0);
      read_result("midop_result_cleared");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_core_bus.md
Name: aes_core_bus

Overview:
- AES-128/256 block cipher behind a narrow register-style bus: 4-bit address, 16-bit write data, 8-bit registered read data.
- Host loads config, key and plaintext as 16-bit words, pulses init (key expansion) and next (block processing), polls status, then streams the 16-byte result out.
- Iterative core: one round per clock, round keys stored internally.

Parameters:
- None. Address map, bus widths and round counts are fixed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- address  input  4  command/register select, sampled every rising edge
- data_in  input  16  write data, sampled every rising edge
- data_out  output  8  registered read data

Behaviour:
- Address map:
  - 0 IDLE
  - 1 CONFIG
  - 2 KEY
  - 3 BLOCK
  - 5 STATUS
  - 6 START
  - 7 RESULT
  - 4 and 8-F behave as IDLE.
- Reset (async): data_out=0, encdec=0, keylen=0, ready=0, valid=0; key, block, round keys and result cleared; both FSMs to IDLE.
- data_out update rule:
  - data_out is a register, updated on every edge.
  - It is 0 unless the rules below (STATUS, START readback, result streaming) load a value.
- Bus FSM states: IDLE, LOAD_KEY, LOAD_BLOCK, READ_RESULT.
- IDLE, address=CONFIG: encdec<=data_in[0] (1=encrypt); keylen<=data_in[1] (0=128-bit, 1=256-bit).
- IDLE, address=KEY: go to LOAD_KEY.
  - Next 16 edges (keylen=1) or 8 edges (keylen=0) capture data_in as key words, MSB word first.
  - address is ignored during the load; then return to IDLE.
- IDLE, address=BLOCK: go to LOAD_BLOCK; next 8 edges capture 128-bit block words, MSB first; then IDLE.
- IDLE, address=START: init=data_in[0], next=data_in[1], both one-cycle pulses. data_out<={4'b0,keylen,encdec,data_in[1],data_in[0]}.
- Any state, address=STATUS: data_out<={6'b0,valid,ready}. data_in is ignored.
- IDLE, address=RESULT:
  - data_out<=result[127:120] and go to READ_RESULT.
  - The next 15 edges output bytes 1..15 (MSB order) regardless of address.
  - Then ready<=1 and return to IDLE.
- Core FSM states: IDLE, KEYEXP, ROUND.
- init in core IDLE:
  - ready<=0, valid<=0.
  - Expand the key into Nr+1 round keys (Nr=10 or 14), one 128-bit round key per cycle, stored in registers.
  - ready<=1 when done; must complete within Nr+3 edges.
- next in core IDLE with round keys valid:
  - ready<=0, valid<=0.
  - Initial AddRoundKey, then Nr rounds at one per cycle; last round omits MixColumns.
  - result latched, valid<=1, ready stays 0.
  - valid asserts at most Nr+2 edges after the edge capturing next.
- next before any completed init: ignored, status unchanged.
- CONFIG/KEY/BLOCK/START are ignored while the core is not IDLE; STATUS and RESULT remain serviced.
- Changing keylen without re-running init leaves ready=0 until init.
- init and next both set in one START write: init wins.
- Reset mid-operation aborts everything immediately; all state returns to reset values.

Optional Feature:
- Macro: AES_DECRYPT_EN.
- Defined:
  - encdec=0 selects decryption: inverse cipher with InvSubBytes, InvShiftRows and InvMixColumns.
  - Round keys are applied in reverse order.
  - Same latency as encryption.
- Undefined:
  - encdec is still stored and read back, but the operation always encrypts.
  - No inverse datapath is built.

Test Plan:
- Reset, then address IDLE with data_in=16'habcd for several cycles -> data_out stays 8'h00.
- CONFIG write data_in=16'h0003, then START write data_in=0 -> data_out=8'b00001100 on the edge after START.
- AES-256 encrypt:
  - Key 000102...1e1f, init; poll STATUS -> 8'h01.
  - Block 00112233445566778899aabbccddeeff, next; poll STATUS -> 8'h02 within 16 edges.
  - RESULT stream -> 8ea2b7ca516745bfeafc49904b496089.
- AES-128 encrypt (keylen=0), key 000102...0f, same block -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back:
  - 100 iterations of key load + init + next + readout -> each golden matches.
  - STATUS reads 8'h03 after readout and 8'h00 during expansion.
- With AES_DECRYPT_EN, encdec=0, AES-256 key above, block 8ea2b7ca...6089 -> 00112233445566778899aabbccddeeff. Without the macro -> encryption result.
